serial_work_link: RTL and testbench



---
 rtl/serial_work_link.sv | 218 +++++++++++++++++++++
 tb/tb_serial_work_link.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_work_link.sv
`timescale 1ns/1ps
// UART work link: assembles 44-byte work packets from RxD into midstate/data2
// and serialises 32-bit nonces back on TxD, both 8N1 at CLK_HZ/BAUD cycles per bit.
module serial_work_link #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int GAP_CYCLES = CLK_HZ / 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RxD,
  output logic         TxD,
  output logic [255:0] midstate,
  output logic [95:0]  data2,
  output logic         new_work,
  input  logic         send,
  input  logic [31:0]  word,
  output logic         busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int GW   = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic {TX_IDLE, TX_ACTIVE} txState_t;

  rxState_t       r_rxState, w_rxNext;
  logic [1:0]     r_rxSync;
  logic           w_rx;
  logic [CW-1:0]  r_rxCnt;
  logic [2:0]     r_rxBit;
  logic [7:0]     r_rxByte;
  logic [351:0]   r_rxBuf;
  logic [351:0]   w_nextBuf;
  logic [5:0]     r_byteCnt;
  logic [GW-1:0]  r_gapCnt;
  logic [255:0]   r_midstate;
  logic [95:0]    r_data2;
  logic           r_newWork;
  logic           w_rxCntClr, w_rxShiftBit, w_rxStopSample, w_byteOk;

  txState_t       r_txState, w_txNext;
  logic [31:0]    r_txWord;
  logic [CW-1:0]  r_txCnt;
  logic [3:0]     r_txBit;
  logic [1:0]     r_txByteIdx;
  logic           r_txD;
  logic           w_txAccept, w_txBitEnd, w_txDone, w_txDataBit;

  assign w_rx      = r_rxSync[1];
  assign w_byteOk  = w_rxStopSample & w_rx;
  assign w_nextBuf = {r_rxByte, r_rxBuf[351:8]};

  assign TxD      = r_txD;
  assign busy     = (r_txState == TX_ACTIVE);
  assign midstate = r_midstate;
  assign data2    = r_data2;
  assign new_work = r_newWork;

  always_ff @(posedge clk) begin
    if (reset) r_rxSync <= 2'b11;
    else       r_rxSync <= {r_rxSync[0], RxD};
  end

  always_ff @(posedge clk) begin
    if (reset) r_rxState <= RX_IDLE;
    else       r_rxState <= w_rxNext;
  end

  always_comb begin
    w_rxNext       = r_rxState;
    w_rxCntClr     = 1'b0;
    w_rxShiftBit   = 1'b0;
    w_rxStopSample = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        if (!w_rx) begin
          w_rxNext   = RX_START;
          w_rxCntClr = 1'b1;
        end
      end
      RX_START: begin
        if (r_rxCnt == HALF_LAST) begin
          w_rxCntClr = 1'b1;
          w_rxNext   = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rxCnt == DIV_LAST) begin
          w_rxCntClr   = 1'b1;
          w_rxShiftBit = 1'b1;
          if (r_rxBit == 3'd7) w_rxNext = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rxCnt == DIV_LAST) begin
          w_rxStopSample = 1'b1;
          w_rxNext       = RX_IDLE;
        end
      end
      default: w_rxNext = RX_IDLE;
    endcase
  end

  // A byte with a bad stop bit never reaches the buffer, so the byte count stays aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxCnt    <= '0;
      r_rxBit    <= '0;
      r_rxByte   <= '0;
      r_rxBuf    <= '0;
      r_byteCnt  <= '0;
      r_gapCnt   <= '0;
      r_midstate <= '0;
      r_data2    <= '0;
      r_newWork  <= 1'b0;
    end else begin
      r_newWork <= 1'b0;
      if (w_rxCntClr || r_rxState == RX_IDLE) r_rxCnt <= '0;
      else                                     r_rxCnt <= r_rxCnt + CW'(1);
      if (r_rxState == RX_START) r_rxBit <= '0;
      else if (w_rxShiftBit)     r_rxBit <= r_rxBit + 3'd1;
      if (w_rxShiftBit) r_rxByte <= {w_rx, r_rxByte[7:1]};
      if (w_byteOk) begin
        r_rxBuf <= w_nextBuf;
        if (r_byteCnt == 6'd43) begin
          r_byteCnt  <= '0;
          r_midstate <= w_nextBuf[255:0];
          r_data2    <= w_nextBuf[351:256];
          r_newWork  <= 1'b1;
        end else begin
          r_byteCnt <= r_byteCnt + 6'd1;
        end
      end
      if (r_rxState == RX_IDLE && r_byteCnt != 6'd0) begin
        if (r_gapCnt == GAP_LAST) begin
          r_gapCnt  <= '0;
          r_byteCnt <= '0;
        end else begin
          r_gapCnt <= r_gapCnt + GW'(1);
        end
      end else begin
        r_gapCnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_txState <= TX_IDLE;
    else       r_txState <= w_txNext;
  end

  always_comb begin
    w_txNext   = r_txState;
    w_txAccept = 1'b0;
    w_txBitEnd = 1'b0;
    w_txDone   = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        if (send) begin
          w_txAccept = 1'b1;
          w_txNext   = TX_ACTIVE;
        end
      end
      TX_ACTIVE: begin
        if (r_txCnt == DIV_LAST) begin
          w_txBitEnd = 1'b1;
          if (r_txBit == 4'd9 && r_txByteIdx == 2'd3) begin
            w_txDone = 1'b1;
            w_txNext = TX_IDLE;
          end
        end
      end
      default: w_txNext = TX_IDLE;
    endcase
  end

  // Frame bit index 0 is start, 1..8 data, 9 stop; the next data bit is word bit r_txBit.
  assign w_txDataBit = r_txWord[{r_txByteIdx, r_txBit[2:0]}];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_txD       <= 1'b1;
      r_txWord    <= '0;
      r_txCnt     <= '0;
      r_txBit     <= '0;
      r_txByteIdx <= '0;
    end else if (w_txAccept) begin
      r_txWord    <= word;
      r_txD       <= 1'b0;
      r_txCnt     <= '0;
      r_txBit     <= '0;
      r_txByteIdx <= '0;
    end else if (r_txState == TX_ACTIVE) begin
      if (w_txBitEnd) begin
        r_txCnt <= '0;
        if (w_txDone) begin
          r_txD <= 1'b1;
        end else if (r_txBit == 4'd9) begin
          r_txBit     <= '0;
          r_txByteIdx <= r_txByteIdx + 2'd1;
          r_txD       <= 1'b0;
        end else begin
          r_txBit <= r_txBit + 4'd1;
          r_txD   <= (r_txBit == 4'd8) ? 1'b1 : w_txDataBit;
        end
      end else begin
        r_txCnt <= r_txCnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_work_link.sv
`timescale 1ns/1ps
// Self-checking bench for serial_work_link at DIV=16: table-driven TX vectors decoded
// off TxD, and a packet scoreboard filled when RX bytes are driven and drained on new_work.
module tb_serial_work_link;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int GAP    = 2000;
  localparam int BIT_NS = 160;

  logic         clk;
  logic         reset;
  logic         RxD;
  logic         TxD;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic         new_work;
  logic         send;
  logic [31:0]  word;
  logic         busy;

  serial_work_link #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .TxD(TxD), .midstate(midstate),
    .data2(data2), .new_work(new_work), .send(send), .word(word), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] wireBytes;
  } txVec_t;

  typedef struct {
    logic [255:0] ms;
    logic [95:0]  d2;
  } pkt_t;

  txVec_t      txVec [4];
  pkt_t        pktQ [$];
  pkt_t        gotPkt;
  logic [7:0]  txQ [$];
  logic [7:0]  pktBytes [44];
  int          total = 0;
  int          bad = 0;
  int          newWorkCount = 0;
  int          busyCycles = 0;

  task automatic checkOutput(input string name, input logic [351:0] act, input logic [351:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Each new_work pulse must match the oldest packet still expected by the scoreboard.
  always @(negedge clk) begin
    if (!reset && new_work === 1'b1) begin
      newWorkCount++;
      if (pktQ.size() == 0) begin
        checkOutput("unexpected_new_work", 1, 0);
      end else begin
        gotPkt = pktQ.pop_front();
        checkOutput("pkt_midstate", midstate, gotPkt.ms);
        checkOutput("pkt_data2", data2, gotPkt.d2);
      end
    end
  end

  always @(negedge clk) if (busy === 1'b1) busyCycles++;

  task automatic sendByte(input logic [7:0] b, input logic stopVal, input int bitNs);
    RxD = 1'b0;
    #(bitNs);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      #(bitNs);
    end
    RxD = stopVal;
    #(bitNs);
    RxD = 1'b1;
  endtask

  task automatic sendPacket(input string name, input int bitNs);
    logic [351:0] full;
    pkt_t p;
    for (int k = 0; k < 44; k++) full[8*k +: 8] = pktBytes[k];
    p.ms = full[255:0];
    p.d2 = full[351:256];
    pktQ.push_back(p);
    for (int k = 0; k < 44; k++) sendByte(pktBytes[k], 1'b1, bitNs);
    for (int w = 0; w < 200 && pktQ.size() != 0; w++) @(negedge clk);
    checkOutput({name, "_arrived"}, pktQ.size(), 0);
    pktQ.delete();
  endtask

  // Sends one table vector, decodes the four frames off TxD at bit centres, and fires
  // an extra send at cycle 100 that must be ignored.
  task automatic applyStimulus(input int v);
    logic [9:0] frame;
    logic [7:0] expByte;
    int bitIdx;
    @(negedge clk);
    send = 1'b1;
    word = txVec[v].w;
    for (int i = 0; i < 4; i++) txQ.push_back(txVec[v].wireBytes[31-8*i -: 8]);
    busyCycles = 0;
    @(negedge clk);
    send = 1'b0;
    checkOutput("tx_latency", {busy, TxD}, 2'b10);
    for (int k = 0; k < 640; k++) begin
      if (k == 100) begin
        send = 1'b1;
        word = ~txVec[v].w;
      end
      if (k == 101) send = 1'b0;
      if (k % 16 == 8) begin
        bitIdx = k / 16;
        frame[bitIdx % 10] = TxD;
        if (bitIdx % 10 == 9) begin
          expByte = txQ.pop_front();
          checkOutput("tx_frame", frame, {1'b1, expByte, 1'b0});
        end
      end
      @(negedge clk);
    end
    checkOutput("tx_done_state", {busy, TxD}, 2'b01);
    repeat (50) @(negedge clk);
    checkOutput("tx_busy_cycles", busyCycles, 640);
    checkOutput("tx_idle_after", {busy, TxD}, 2'b01);
  endtask

  initial begin
    int badIdle;
    int nwBefore;
    txVec[0] = '{32'h12345678, 32'h78563412};
    txVec[1] = '{32'hA5C30FF0, 32'hF00FC3A5};
    txVec[2] = '{32'h00000000, 32'h00000000};
    txVec[3] = '{32'h80000001, 32'h01000080};

    RxD   = 1'b1;
    send  = 1'b0;
    word  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_txd", TxD, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_midstate", midstate, '0);
    checkOutput("reset_data2", data2, '0);
    checkOutput("reset_new_work", new_work, 1'b0);
    badIdle = 0;
    repeat (1000) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0 || new_work !== 1'b0 || midstate !== '0) badIdle++;
    end
    checkOutput("idle_1000", badIdle, 0);

    for (int v = 0; v < 4; v++) applyStimulus(v);

    $display("[TB] rx counting packet");
    for (int k = 0; k < 44; k++) pktBytes[k] = 8'(k);
    nwBefore = newWorkCount;
    sendPacket("rx_count", BIT_NS);
    checkOutput("rx_ms_lo", midstate[7:0], 8'h00);
    checkOutput("rx_ms_hi", midstate[255:248], 8'h1F);
    checkOutput("rx_d2_lo", data2[7:0], 8'h20);
    checkOutput("rx_d2_hi", data2[95:88], 8'h2B);
    checkOutput("rx_once", newWorkCount - nwBefore, 1);

    $display("[TB] glitch and framing error");
    RxD = 1'b0;
    #40;
    RxD = 1'b1;
    #2000;
    sendByte(8'h5A, 1'b0, BIT_NS);
    #400;
    for (int k = 0; k < 44; k++) pktBytes[k] = 8'((k * 7 + 3) & 8'hFF);
    sendPacket("rx_framing", BIT_NS);

    $display("[TB] rate tolerance");
    for (int k = 0; k < 44; k++) pktBytes[k] = 8'($urandom_range(0, 255));
    sendPacket("rx_fast", 157);
    for (int k = 0; k < 44; k++) pktBytes[k] = 8'($urandom_range(0, 255));
    sendPacket("rx_slow", 163);

    $display("[TB] gap timeout");
    for (int k = 0; k < 10; k++) sendByte(8'h11, 1'b1, BIT_NS);
    repeat (3000) @(negedge clk);
    for (int k = 0; k < 44; k++) pktBytes[k] = 8'hA5;
    sendPacket("rx_gap", BIT_NS);
    checkOutput("gap_all_a5", {data2, midstate}, {44{8'hA5}});

    $display("[TB] reset mid operation");
    for (int k = 0; k < 20; k++) sendByte(8'h33, 1'b1, BIT_NS);
    @(negedge clk);
    send = 1'b1;
    word = 32'h0BADF00D;
    @(negedge clk);
    send = 1'b0;
    repeat (370) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_txd", TxD, 1'b1);
    checkOutput("mid_reset_busy", busy, 1'b0);
    checkOutput("mid_reset_outputs", {data2, midstate}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    badIdle = 0;
    repeat (200) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) badIdle++;
    end
    checkOutput("post_reset_quiet", badIdle, 0);
    for (int k = 0; k < 44; k++) pktBytes[k] = 8'(k) ^ 8'h5C;
    sendPacket("rx_after_reset", BIT_NS);

    checkOutput("new_work_total", newWorkCount, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    bad++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
